// File: rtl/mdio_master.sv
// Clause 22 MDIO management master with an internal MDC divider.
// Commands use a valid/ready channel and read results return on a rsp_* pulse.
module mdio_master #(
    parameter int CLK_DIV_HALF = 25,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    input  logic        cfg_preamble_suppress,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t
);

    localparam int DIV_W = $clog2(CLK_DIV_HALF);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV_HALF - 1);
    localparam logic [5:0] PRE_LAST = (PREAMBLE_LEN > 0) ? 6'(PREAMBLE_LEN - 1) : 6'd0;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_TA   = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    generate
        if (CLK_DIV_HALF < 2) begin : g_div_check
            $error("mdio_master: CLK_DIV_HALF must be at least 2");
        end
        if (PREAMBLE_LEN < 0 || PREAMBLE_LEN > 32) begin : g_pre_check
            $error("mdio_master: PREAMBLE_LEN must be within 0..32");
        end
    endgenerate

    logic [2:0]       state;
    logic [5:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             wr_q;
    logic [31:0]      tx_sr;
    logic [15:0]      rx_sr;
    logic             ta_err;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = ~cmd_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            wr_q      <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            ta_err    <= 1'b0;
            mdc       <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_t    <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == S_IDLE) begin
                mdc     <= 1'b0;
                div_cnt <= '0;
                if (cmd_valid) begin
                    // ST/OP/PHYAD/REGAD/TA/DATA packed MSB-first; read tail is all ones
                    wr_q   <= cmd_write;
                    tx_sr  <= {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr, cmd_reg_addr,
                               (cmd_write ? {2'b10, cmd_wdata} : 18'h3FFFF)};
                    mdio_t <= 1'b0;
                    if (!cfg_preamble_suppress && PREAMBLE_LEN > 0) begin
                        state   <= S_PRE;
                        bit_cnt <= PRE_LAST;
                        mdio_o  <= 1'b1;
                    end else begin
                        state   <= S_HDR;
                        bit_cnt <= 6'd13;
                        mdio_o  <= 1'b0;
                    end
                end
            end else if (div_cnt != DIV_LAST) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
                mdc     <= ~mdc;
                if (!mdc) begin
                    // rising MDC: capture PHY-driven bits
                    if (state == S_TA && bit_cnt == '0) ta_err <= mdio_i;
                    if (state == S_DATA) rx_sr <= {rx_sr[14:0], mdio_i};
                end else begin
                    bit_cnt <= bit_cnt - 1'b1;
                    if (state != S_PRE) begin
                        tx_sr  <= {tx_sr[30:0], 1'b0};
                        mdio_o <= tx_sr[30];
                    end
                    case (state)
                        S_PRE: if (bit_cnt == '0) begin
                            state   <= S_HDR;
                            bit_cnt <= 6'd13;
                            mdio_o  <= tx_sr[31];
                        end
                        S_HDR: if (bit_cnt == '0) begin
                            state   <= S_TA;
                            bit_cnt <= 6'd1;
                            mdio_t  <= ~wr_q;
                        end
                        S_TA: if (bit_cnt == '0) begin
                            state   <= S_DATA;
                            bit_cnt <= 6'd15;
                        end
                        S_DATA: if (bit_cnt == '0) begin
                            state   <= S_DONE;
                            bit_cnt <= '0;
                            mdio_t  <= 1'b1;
                            mdio_o  <= 1'b1;
                        end
                        S_DONE: begin
                            state     <= S_IDLE;
                            bit_cnt   <= '0;
                            mdio_o    <= 1'b1;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= wr_q ? 16'h0000 : rx_sr;
                            rsp_error <= ~wr_q & ta_err;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Randomised self-checking bench for mdio_master against a bit-level frame model.
module tb_mdio_master;

    localparam int H = 2;
    localparam int P = 32;

    typedef struct packed {
        logic        wr;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wd;
        logic        sup;
        logic        present;
        logic [15:0] rd;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_phy_addr = '0;
    logic [4:0]  cmd_reg_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic        cfg_preamble_suppress = 1'b0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;
    logic        mdc;
    logic        mdio_i = 1'b1;
    logic        mdio_o;
    logic        mdio_t;

    int n_checks = 0;
    int n_fail = 0;

    bit exp_bit[$];
    bit exp_drv[$];

    mdio_master #(.CLK_DIV_HALF(H), .PREAMBLE_LEN(P)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
        .cfg_preamble_suppress(cfg_preamble_suppress),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy),
        .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_t(mdio_t)
    );

    always #4 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_field(input logic [15:0] val, input int width, input bit drv);
        for (int i = width - 1; i >= 0; i--) begin
            exp_bit.push_back(val[i]);
            exp_drv.push_back(drv);
        end
    endtask

    // Frame as seen on the wire: preamble, ST, OP, PHYAD, REGAD, TA, DATA
    task automatic build_frame(input cmd_t c);
        exp_bit.delete();
        exp_drv.delete();
        if (!c.sup) push_field(16'hFFFF, P > 16 ? 16 : P, 1'b1);
        if (!c.sup && P > 16) push_field(16'hFFFF, P - 16, 1'b1);
        push_field(16'b01, 2, 1'b1);
        push_field(c.wr ? 16'b01 : 16'b10, 2, 1'b1);
        push_field({11'd0, c.phy}, 5, 1'b1);
        push_field({11'd0, c.rg}, 5, 1'b1);
        if (c.wr) begin
            push_field(16'b10, 2, 1'b1);
            push_field(c.wd, 16, 1'b1);
        end else begin
            push_field(16'b11, 2, 1'b0);
            push_field(16'hFFFF, 16, 1'b0);
        end
    endtask

    function automatic logic phy_bit(input cmd_t c, input int k, input int peff);
        int ta0 = peff + 14;
        if (c.wr || !c.present || k < ta0 + 1 || k >= peff + 32) return 1'b1;
        if (k == ta0 + 1) return 1'b0;
        return c.rd[15 - (k - ta0 - 2)];
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.wr      = 1'($urandom);
        c.phy     = 5'($urandom);
        c.rg      = 5'($urandom);
        c.wd      = 16'($urandom);
        c.sup     = ($urandom_range(0, 3) == 0);
        c.present = ($urandom_range(0, 3) != 0);
        c.rd      = 16'($urandom);
        return c;
    endfunction

    task automatic drive_cmd(input cmd_t c);
        cmd_write             = c.wr;
        cmd_phy_addr          = c.phy;
        cmd_reg_addr          = c.rg;
        cmd_wdata             = c.wd;
        cfg_preamble_suppress = c.sup;
        cmd_valid             = 1'b1;
    endtask

    task automatic check_reset_values(input string pfx);
        check_eq({pfx, "_mdc"}, mdc, 1'b0);
        check_eq({pfx, "_mdio_o"}, mdio_o, 1'b1);
        check_eq({pfx, "_mdio_t"}, mdio_t, 1'b1);
        check_eq({pfx, "_cmd_ready"}, cmd_ready, 1'b1);
        check_eq({pfx, "_busy"}, busy, 1'b0);
        check_eq({pfx, "_rsp_valid"}, rsp_valid, 1'b0);
        check_eq({pfx, "_rsp_rdata"}, rsp_rdata, 16'h0000);
        check_eq({pfx, "_rsp_error"}, rsp_error, 1'b0);
    endtask

    // start_now: this negedge is already the accept cycle (chained from the previous frame)
    task automatic run_frame(input cmd_t c, input bit start_now, input bit chain,
                             input cmd_t nxt, input int abort_bit);
        int n, t, k, pos, peff;
        logic [15:0] exp_rd;
        logic exp_err;
        if (!start_now) begin
            int waited = 0;
            @(negedge clk);
            drive_cmd(c);
            while (!cmd_ready && waited < 1000) begin
                @(negedge clk);
                waited++;
            end
            if (!cmd_ready) begin
                check_eq("accept_timeout", 0, 1);
                cmd_valid = 1'b0;
                return;
            end
        end
        check_eq("ready_at_accept", cmd_ready, 1'b1);
        build_frame(c);
        peff = c.sup ? 0 : P;
        n = exp_bit.size();
        t = 1 + 2 * H * (n + 1);
        exp_rd  = c.wr ? 16'h0000 : (c.present ? c.rd : 16'hFFFF);
        exp_err = !c.wr && !c.present;
        for (int cyc = 1; cyc <= t; cyc++) begin
            @(negedge clk);
            k = (cyc - 1) / (2 * H);
            pos = (cyc - 1) % (2 * H);
            mdio_i = phy_bit(c, k, peff);
            if (cyc == 1) begin
                if (chain) drive_cmd(nxt);
                else cmd_valid = 1'b0;
                check_eq("ready_drop", cmd_ready, 1'b0);
                check_eq("busy", busy, 1'b1);
            end
            if (k == abort_bit && pos == 0) begin
                #1 reset_n = 1'b0;
                cmd_valid = 1'b0;
                #1 check_reset_values("async_rst");
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check_eq("no_rsp_in_reset", rsp_valid, 1'b0);
                end
                reset_n = 1'b1;
                mdio_i = 1'b1;
                for (int j = 0; j < 2 * H * 3; j++) begin
                    @(negedge clk);
                    check_eq("no_rsp_after_abort", rsp_valid, 1'b0);
                    check_eq("idle_mdc_after_abort", mdc, 1'b0);
                end
                return;
            end
            if (cyc < t) begin
                check_eq("mdc", mdc, (pos >= H));
                check_eq("rsp_valid_early", rsp_valid, 1'b0);
                if (k < n) begin
                    check_eq($sformatf("mdio_t_bit%0d", k), mdio_t, !exp_drv[k]);
                    if (pos == H && exp_drv[k])
                        check_eq($sformatf("mdio_o_bit%0d", k), mdio_o, exp_bit[k]);
                end else begin
                    check_eq("idle_bit_mdio_t", mdio_t, 1'b1);
                    check_eq("idle_bit_mdio_o", mdio_o, 1'b1);
                end
            end else begin
                check_eq("rsp_valid", rsp_valid, 1'b1);
                check_eq("rsp_rdata", rsp_rdata, exp_rd);
                check_eq("rsp_error", rsp_error, exp_err);
                check_eq("ready_at_rsp", cmd_ready, 1'b1);
                check_eq("mdc_at_rsp", mdc, 1'b0);
                check_eq("mdio_t_at_rsp", mdio_t, 1'b1);
            end
        end
        if (!chain) begin
            @(negedge clk);
            check_eq("rsp_valid_pulse_end", rsp_valid, 1'b0);
            check_eq("rsp_rdata_held", rsp_rdata, exp_rd);
            check_eq("rsp_error_held", rsp_error, exp_err);
        end
    endtask

    initial begin
        cmd_t none, c0, c1;
        bit start_now;
        bit ch;
        none = '0;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;

        // write PHY 7 reg 0 data 0x1140, full preamble
        c0 = '{wr: 1'b1, phy: 5'd7, rg: 5'd0, wd: 16'h1140, sup: 1'b0, present: 1'b0, rd: 16'h0};
        run_frame(c0, 1'b0, 1'b0, none, -1);
        // read PHY 7 reg 2 with a responding PHY
        c0 = '{wr: 1'b0, phy: 5'd7, rg: 5'd2, wd: 16'h0, sup: 1'b0, present: 1'b1, rd: 16'h4F51};
        run_frame(c0, 1'b0, 1'b0, none, -1);
        // same read with nothing driving the bus
        c0.present = 1'b0;
        run_frame(c0, 1'b0, 1'b0, none, -1);
        // preamble suppressed write
        c0 = '{wr: 1'b1, phy: 5'd7, rg: 5'd4, wd: 16'h01E1, sup: 1'b1, present: 1'b0, rd: 16'h0};
        run_frame(c0, 1'b0, 1'b0, none, -1);
        // back-to-back writes with cmd_valid held
        c0 = '{wr: 1'b1, phy: 5'd3, rg: 5'd9, wd: 16'hA5C3, sup: 1'b0, present: 1'b0, rd: 16'h0};
        c1 = '{wr: 1'b1, phy: 5'd30, rg: 5'd17, wd: 16'h5A3C, sup: 1'b0, present: 1'b0, rd: 16'h0};
        run_frame(c0, 1'b0, 1'b1, c1, -1);
        run_frame(c1, 1'b1, 1'b0, none, -1);
        // abort a read during DATA bit 5, then a clean read
        c0 = '{wr: 1'b0, phy: 5'd1, rg: 5'd5, wd: 16'h0, sup: 1'b0, present: 1'b1, rd: 16'hBEEF};
        run_frame(c0, 1'b0, 1'b0, none, P + 14 + 2 + 5);
        c0 = '{wr: 1'b0, phy: 5'd1, rg: 5'd6, wd: 16'h0, sup: 1'b0, present: 1'b1, rd: 16'h1234};
        run_frame(c0, 1'b0, 1'b0, none, -1);

        // randomised commands, sometimes chained back-to-back
        c0 = rand_cmd();
        start_now = 1'b0;
        for (int i = 0; i < 14; i++) begin
            c1 = rand_cmd();
            ch = (i < 13) ? 1'($urandom) : 1'b0;
            run_frame(c0, start_now, ch, c1, -1);
            start_now = ch;
            c0 = c1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
